// File: rtl/complete_buffer_if.sv
// Completion-queue bus: functional-unit results in, ROB update lanes out.
// The producer/ROB side uses master, the buffer itself uses slave.
interface complete_buffer_if #(
   parameter int N_IN      = 3,
   parameter int N_OUT     = 2,
   parameter int DEPTH     = 8,
   parameter int ROB_IDX_W = 5,
   parameter int ADDR_W    = 32
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [N_IN-1:0]            in_valid;
   logic [N_IN*ROB_IDX_W-1:0]  in_rob_idx;
   logic [N_IN-1:0]            in_mispredict;
   logic [N_IN-1:0]            in_branch_valid;
   logic [N_IN-1:0]            in_branch_taken;
   logic [N_IN*ADDR_W-1:0]     in_branch_target;
   logic                       in_ready;
   logic                       rob_stall;
   logic                       flush;
   logic [N_OUT-1:0]           upd_valid;
   logic [N_OUT*ROB_IDX_W-1:0] upd_idx;
   logic [N_OUT-1:0]           upd_mispredict;
   logic [N_OUT-1:0]           upd_branch_taken;
   logic [N_OUT*ADDR_W-1:0]    upd_branch_target;
   logic [CNT_W-1:0]           count;
   logic                       overflow_err;

   modport master (
      output in_valid, in_rob_idx, in_mispredict, in_branch_valid,
             in_branch_taken, in_branch_target, rob_stall, flush,
      input  in_ready, upd_valid, upd_idx, upd_mispredict, upd_branch_taken,
             upd_branch_target, count, overflow_err
   );

   modport slave (
      input  in_valid, in_rob_idx, in_mispredict, in_branch_valid,
             in_branch_taken, in_branch_target, rob_stall, flush,
      output in_ready, upd_valid, upd_idx, upd_mispredict, upd_branch_taken,
             upd_branch_target, count, overflow_err
   );
endinterface

// File: rtl/complete_buffer.sv
// Circular completion queue between EX/COMP and the ROB: compacts up to N_IN
// results per cycle and presents the N_OUT oldest entries as ROB update lanes.
module complete_buffer #(
   parameter int N_IN      = 3,
   parameter int N_OUT     = 2,
   parameter int DEPTH     = 8,
   parameter int ROB_IDX_W = 5,
   parameter int ADDR_W    = 32
) (
   input logic              clock,
   input logic              reset_n,
   complete_buffer_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   if (DEPTH != (1 << PTR_W) || DEPTH < N_IN) begin : g_bad_depth
      $error("complete_buffer: DEPTH must be a power of two and >= N_IN");
   end

   typedef struct packed {
      logic [ROB_IDX_W-1:0] rob_idx;
      logic                 mispredict;
      logic                 branch_taken;
      logic [ADDR_W-1:0]    branch_target;
   } entry_t;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;

   logic             in_ready;
   logic [CNT_W-1:0] npush;
   logic [CNT_W-1:0] npop;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Acceptance is decided from the registered occupancy only, so a full
   // group is never refused or admitted based on same-cycle pops.
   assign in_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(N_IN);

   // Compact the valid lanes onto consecutive slots starting at tail.
   always_comb begin
      ent_d  = ent_q;
      npush  = '0;
      wr_ptr = tail_q;
      if (in_ready && !bus.flush) begin
         for (int i = 0; i < N_IN; i++) begin
            if (bus.in_valid[i]) begin
               ent_d[wr_ptr].rob_idx       = bus.in_rob_idx[i*ROB_IDX_W +: ROB_IDX_W];
               ent_d[wr_ptr].mispredict    = bus.in_mispredict[i];
               ent_d[wr_ptr].branch_taken  = bus.in_branch_valid[i] & bus.in_branch_taken[i];
               ent_d[wr_ptr].branch_target = bus.in_branch_valid[i] ?
                                             bus.in_branch_target[i*ADDR_W +: ADDR_W] : '0;
               wr_ptr = wr_ptr + PTR_W'(1);
               npush  = npush + CNT_W'(1);
            end
         end
      end
   end

   always_comb begin
      npop = '0;
      if (!bus.rob_stall && !bus.flush) begin
         npop = (count_q < CNT_W'(N_OUT)) ? count_q : CNT_W'(N_OUT);
      end
      head_d  = head_q + npop[PTR_W-1:0];
      tail_d  = tail_q + npush[PTR_W-1:0];
      count_d = count_q + npush - npop;
      ovf_d   = ovf_q | ((|bus.in_valid) & ~in_ready);
      if (bus.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   // Lanes beyond the occupancy read as all-zero rather than stale storage.
   always_comb begin
      bus.upd_valid         = '0;
      bus.upd_idx           = '0;
      bus.upd_mispredict    = '0;
      bus.upd_branch_taken  = '0;
      bus.upd_branch_target = '0;
      rd_ptr                = head_q;
      for (int j = 0; j < N_OUT; j++) begin
         rd_ptr = head_q + PTR_W'(j);
         if (CNT_W'(j) < count_q) begin
            bus.upd_valid[j]                         = 1'b1;
            bus.upd_idx[j*ROB_IDX_W +: ROB_IDX_W]    = ent_q[rd_ptr].rob_idx;
            bus.upd_mispredict[j]                    = ent_q[rd_ptr].mispredict;
            bus.upd_branch_taken[j]                  = ent_q[rd_ptr].branch_taken;
            bus.upd_branch_target[j*ADDR_W +: ADDR_W] = ent_q[rd_ptr].branch_target;
         end
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.count        = count_q;
   assign bus.overflow_err = ovf_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   // Storage carries data only; occupancy alone decides what is visible.
   always_ff @(posedge clock) begin
      ent_q <= ent_d;
   end
endmodule

// File: doc/complete_buffer.md
Name: complete_buffer

Overview:
Parametrised successor to the complete stage. Accepts up to N_IN functional-unit results per cycle into a circular completion queue, and drains up to N_OUT oldest entries per cycle as ROB update lanes. Supports ROB backpressure, flush and overflow detection. Sits between the EX/COMP pipe register and the ROB.

Parameters:
N_IN, 3, input result lanes per cycle
N_OUT, 2, ROB update lanes per cycle
DEPTH, 8, queue entries; power of 2, DEPTH >= N_IN
ROB_IDX_W, 5, ROB index width
ADDR_W, 32, branch target width

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  N_IN  per-lane result valid
in_rob_idx  in  N_IN*ROB_IDX_W  per-lane ROB index; lane i at bits [i*ROB_IDX_W +: ROB_IDX_W]
in_mispredict  in  N_IN  per-lane mispredict
in_branch_valid  in  N_IN  lane carries branch info
in_branch_taken  in  N_IN  branch outcome
in_branch_target  in  N_IN*ADDR_W  branch target
in_ready  out  1  queue can accept a full N_IN group this cycle
rob_stall  in  1  ROB cannot accept updates this cycle
flush  in  1  discard all queued entries
upd_valid  out  N_OUT  update lane valid
upd_idx  out  N_OUT*ROB_IDX_W  ROB index
upd_mispredict  out  N_OUT  mispredict
upd_branch_taken  out  N_OUT  taken; 0 if not a branch
upd_branch_target  out  N_OUT*ADDR_W  target; 0 if not a branch
count  out  $clog2(DEPTH)+1  occupied entries
overflow_err  out  1  sticky: a push arrived while in_ready=0

Behaviour:
- Reset (reset_n=0, async): head, tail, count=0; overflow_err=0; storage need not clear. All upd_* read 0, in_ready=1.
- Entry fields: rob_idx, mispredict, branch_taken, branch_target. On write, taken/target are forced to 0 when branch_valid=0.
- in_ready = (DEPTH - count) >= N_IN, from registered count only. It does not depend on same-cycle pops.
- Push: if in_ready=1 and flush=0, valid lanes are written compacted, lowest lane index first, at tail, tail+1, ... Tail advances by popcount(in_valid). Invalid lanes occupy no entry.
- Push while in_ready=0: all lanes dropped, overflow_err set to 1, held until reset.
- Output: combinational from storage. Lane j presents entry head+j when j < count, else upd_valid[j]=0 and all lane-j fields are 0. Lane 0 is always the oldest entry.
- Latency: a result pushed at edge t appears on upd lanes in the cycle after edge t. No input-to-output bypass.
- Pop: if rob_stall=0 and flush=0, head advances by npop = min(count, N_OUT) at the edge. If rob_stall=1, npop=0 and outputs hold.
- Pops take only entries present at cycle start. count_next = count + npush - npop. Pointers wrap modulo DEPTH.
- Full (count=DEPTH): in_ready=0. Empty: all upd_valid=0 and pop is a no-op.
- Flush: at the edge, head=tail=0 and count=0. Same-cycle push and pop are discarded. Flush beats rob_stall. overflow_err is unaffected. Outputs are not masked in the flush cycle itself.
- Reset mid-operation: queue contents are lost immediately, with no partial state.
- Order is strict FIFO across cycles and in lane order within a cycle. No reordering.

Test Plan:
- Reset, then push lanes {1,1,1}, idx {3,4,5}, rob_stall=0 -> next cycle upd_valid=2'b11, idx {3,4}; following cycle upd_valid=2'b01, idx {5}; then count=0.
- in_valid=3'b101, idx {7,x,9}, lane0 branch_valid=0 with taken=1 and target=0x100; lane2 branch_valid=1, taken=1, target=0x200 -> lanes present {7,9}; lane0 taken/target=0, lane1 taken=1, target=0x200.
- Hold rob_stall=1 and push 3 groups of 3 with DEPTH=8 -> count reaches 6 and in_ready=0; the third group is dropped and overflow_err=1 stays high after the stall releases; drain order is idx pushed sequence.
- Wrap: push and pop continuously for 20 cycles with idx incrementing mod 32 -> output idx sequence is contiguous, with no loss or duplication across pointer wrap.
- flush with count=5 plus a same-cycle push of 3 -> next cycle count=0, upd_valid=0, overflow_err unchanged; the next push idx {1,2} appears in the following cycle.
- Assert reset_n low mid-cycle with count=4 -> outputs zero and in_ready=1 immediately, without waiting for a clock edge.
